// File: rtl/mbist_march_ctrl_if.sv
// Memory-side port bundle between the March BIST controller and the fault_mem macro.
interface mbist_march_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  mem_write_read;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_write_read,
        output mem_address,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_write_read,
        input  mem_address,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller for the single-port fault_mem macro: drives the memory
// port, checks read data through a 2-stage compare pipeline, and records first-failure info.
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LAST_ADDR  = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [7:0]            err_count,
    mbist_march_ctrl_if.master    mem
);

    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(LAST_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state;
    logic [2:0]            elem;
    logic                  phase;
    logic                  drain_cnt;

    logic                  s1_valid, s2_valid;
    logic [DATA_WIDTH-1:0] s1_exp, s2_exp;
    logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
    logic [2:0]            s1_elem, s2_elem;

    logic                  rd_op;
    logic                  miscmp;
    logic [7:0]            err_next;
    logic                  two_op;
    logic                  at_end;
    logic [2:0]            elem_inc;

    // E3 and E4 descend; every other element ascends.
    function automatic logic elem_up(input logic [2:0] e);
        return !(e == 3'd3 || e == 3'd4);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] write_pat(input logic [2:0] e);
        return (e == 3'd1 || e == 3'd3) ? '1 : '0;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_pat(input logic [2:0] e);
        return (e == 3'd2 || e == 3'd4) ? '1 : '0;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] start_addr(input logic [2:0] e);
        return elem_up(e) ? '0 : LAST_A;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] end_addr(input logic [2:0] e);
        return elem_up(e) ? LAST_A : '0;
    endfunction

    always_comb begin
        rd_op    = (state == S_RUN) && !mem.mem_write_read;
        miscmp   = s2_valid && (mem.mem_rdata != s2_exp);
        err_next = err_count;
        if (miscmp && err_count != 8'hFF) begin
            err_next = err_count + 8'd1;
        end
        two_op   = (elem != 3'd0) && (elem != 3'd5);
        at_end   = (mem.mem_address == end_addr(elem));
        elem_inc = elem + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            elem               <= '0;
            phase              <= 1'b0;
            drain_cnt          <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            fail_addr          <= '0;
            fail_elem          <= '0;
            fail_data          <= '0;
            err_count          <= '0;
            mem.mem_write_read <= 1'b0;
            mem.mem_address    <= '0;
            mem.mem_wdata      <= '0;
            s1_valid           <= 1'b0;
            s1_exp             <= '0;
            s1_addr            <= '0;
            s1_elem            <= '0;
            s2_valid           <= 1'b0;
            s2_exp             <= '0;
            s2_addr            <= '0;
            s2_elem            <= '0;
        end else begin
            // A read is tagged on the edge that issues it; its data is checked two edges later.
            s1_valid <= rd_op;
            s1_exp   <= read_pat(elem);
            s1_addr  <= mem.mem_address;
            s1_elem  <= elem;
            s2_valid <= s1_valid;
            s2_exp   <= s1_exp;
            s2_addr  <= s1_addr;
            s2_elem  <= s1_elem;

            err_count <= err_next;
            if (miscmp && err_count == 8'd0) begin
                fail_addr <= s2_addr;
                fail_elem <= s2_elem;
                fail_data <= mem.mem_rdata;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        busy               <= 1'b1;
                        done               <= 1'b0;
                        pass               <= 1'b0;
                        fail_addr          <= '0;
                        fail_elem          <= '0;
                        fail_data          <= '0;
                        err_count          <= '0;
                        elem               <= 3'd0;
                        phase              <= 1'b0;
                        mem.mem_address    <= start_addr(3'd0);
                        mem.mem_wdata      <= write_pat(3'd0);
                        mem.mem_write_read <= 1'b0;
                        state              <= S_PREP;
                    end
                end

                S_PREP: begin
                    phase              <= 1'b0;
                    mem.mem_write_read <= (elem == 3'd0);
                    state              <= S_RUN;
                end

                // Outputs hold the operation in flight; this edge selects the next one.
                S_RUN: begin
                    if (two_op && !phase) begin
                        phase              <= 1'b1;
                        mem.mem_write_read <= 1'b1;
                    end else if (at_end) begin
                        phase              <= 1'b0;
                        mem.mem_write_read <= 1'b0;
                        if (elem == 3'd5) begin
                            drain_cnt <= 1'b0;
                            state     <= S_DRAIN;
                        end else begin
                            elem            <= elem_inc;
                            mem.mem_address <= start_addr(elem_inc);
                            mem.mem_wdata   <= write_pat(elem_inc);
                            state           <= S_PREP;
                        end
                    end else begin
                        phase              <= 1'b0;
                        mem.mem_write_read <= (elem == 3'd0);
                        mem.mem_address    <= elem_up(elem) ? mem.mem_address + 1'b1
                                                            : mem.mem_address - 1'b1;
                    end
                end

                S_DRAIN: begin
                    mem.mem_write_read <= 1'b0;
                    drain_cnt          <= 1'b1;
                    if (drain_cnt) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 8'd0);
                        state <= S_DONE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

Built-in self-test controller that runs a March C- algorithm over the single-port `fault_mem` macro. It drives the memory's `write_read`/`address`/`wdata` pins directly and honours the macro's one-cycle write-data lead and two-cycle read latency. It compares every read against the expected background and reports pass/fail plus first-failure diagnostics to the test wrapper. It sits between the chip-level test-mode logic and the memory instance, and owns the memory port while `busy` is high.

## Interface
Parameters:
- `DATA_WIDTH`, 8, memory word width.
- `ADDR_WIDTH`, 4, memory address width.
- `LAST_ADDR`, 2**ADDR_WIDTH-1, highest address tested; the test covers 0..LAST_ADDR, so N = LAST_ADDR+1 words.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `start`  in  1  request to run a test; sampled only in IDLE or DONE.
- `busy`  out  1  test in progress.
- `done`  out  1  test complete; held until the next accepted `start`.
- `pass`  out  1  valid when `done`=1; 1 means zero miscompares.
- `fail_addr`  out  ADDR_WIDTH  address of the first miscompare.
- `fail_elem`  out  3  March element index (0..5) of the first miscompare.
- `fail_data`  out  DATA_WIDTH  read data observed at the first miscompare.
- `err_count`  out  8  total miscompares; saturates at 255.
- `mem_write_read`  out  1  to memory `write_read`: 1 = write, 0 = read.
- `mem_address`  out  ADDR_WIDTH  to memory `address`.
- `mem_wdata`  out  DATA_WIDTH  to memory `wdata`.
- `mem_rdata`  in  DATA_WIDTH  from memory `rdata`.

## Operation
- March C- elements, with B0 = all-zeros and B1 = all-ones:
  - E0 ⇑(w0)
  - E1 ⇑(r0,w1)
  - E2 ⇑(r1,w0)
  - E3 ⇓(r0,w1)
  - E4 ⇓(r1,w0)
  - E5 ⇑(r0)
- ⇑ runs address 0→LAST_ADDR; ⇓ runs LAST_ADDR→0.
- FSM states:
  - IDLE: on `start`=1, clear `done`/`pass`/`fail_*`/`err_count`, set `busy`, element=0, go to PREP.
  - PREP: one cycle. Load `mem_wdata` with the current element's write pattern (E5, which has no write, holds B0). Load the address counter with the element's start address. Drive `mem_write_read`=0. Go to RUN.
  - RUN: issue one operation per cycle in element order (read then write at the same address for two-op elements), then step the address.
    - After the last operation of E0..E4: element+1, go to PREP.
    - After E5's last read: go to DRAIN.
  - DRAIN: 2 cycles; `mem_write_read`=0, no new compares issued.
  - DONE: `busy`=0, `done`=1, `pass`=(`err_count`==0). Go to IDLE state behaviour on the next `start`.
- `mem_wdata` stays constant for the whole of PREP plus RUN of each element. This satisfies the memory's requirement that write data be presented one cycle before the write strobe.
- Compare pipeline: each read issued in RUN pushes {valid, expected, address, element} into a 2-stage shift register. At stage 2, `mem_rdata` is compared with expected.
  - On mismatch: `err_count`+1 (saturating at 255).
  - On the first mismatch only: capture `fail_addr`/`fail_elem`/`fail_data`.
- Non-test reads (PREP, DRAIN, IDLE, DONE) never enter the pipeline.
- `start` while `busy` is ignored.
- `rst_n` low at any time: every register returns to its reset value and the FSM returns to IDLE; a partial test leaves no residue.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `fail_addr`=0, `fail_elem`=0, `fail_data`=0, `err_count`=0, `mem_write_read`=0, `mem_address`=0, `mem_wdata`=0.
- Memory contract:
  - A write at edge k stores the `mem_wdata` that was present at edge k-1.
  - A read issued at edge k returns `mem_rdata`, sampled valid at edge k+2.
- `start` sampled at edge 0 → `busy`=1 after edge 0.
- Total busy cycles = 6 (PREP) + 10·N (RUN) + 2 (DRAIN) = 10N+8.
- `done`/`pass` rise together, after the last busy cycle. For N=16: 168 busy cycles.
- The final miscompare (E5, last address) is captured in the last DRAIN cycle, before `done` rises.
- Element boundaries: the last write of an element completes before PREP changes `mem_wdata`.
- `mem_address` wraps only via the explicit counter reload in PREP. The counter never steps past 0 or LAST_ADDR.

## Test plan
- Fault-free memory, N=16, pulse `start` → `busy` high for exactly 168 cycles, then `done`=1, `pass`=1, `err_count`=0.
- Memory with bit 1 of address 5 stuck-at-0 → `pass`=0, `fail_addr`=5, `fail_elem`=2, `fail_data`=8'hFD, `err_count`=2 (E2 r1 and E4 r1).
- Memory returning 8'h00 at every address → first miscompare at `fail_elem`=2, `fail_addr`=0, `fail_data`=8'h00; `err_count`=32.
- Pulse `start` again at cycle 50 of a run → ignored; run still ends at cycle 168 with an identical result.
- Assert `rst_n` low at cycle 80, release, then start a fresh run → all outputs at reset values during reset; the new run completes in 168 cycles with `pass`=1.
- Monitor the memory port during the E1→E2 transition → `mem_wdata` changes 8'hFF→8'h00 only in the PREP cycle, and the last E1 write stores 8'hFF at address 15.
